qdr2_b2_ctrl: RTL and testbench

Host-side controller for the QDR-II burst-of-2, x36 SRAM (the `cyqdr2_b2` device family).
- Accepts independent read and write requests through valid/ready handshakes.
- Sequences the device DLL start-up through DOFF.
- Drives RPS#/WPS#/A/D/BWS# as SDR rise/fall pairs for an external DDR I/O cell.
- Returns tagged 72-bit read bursts after a fixed latency.

---
 rtl/qdr2_pkg.sv | 16 +
 rtl/qdr2_rd_pipe.sv | 44 ++++
 rtl/qdr2_b2_ctrl.sv | 154 +++++++++++++++
 tb/tb_qdr2_b2_ctrl.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/qdr2_pkg.sv
// Shared widths, init FSM states and idle encodings for the QDR-II burst-of-2 x36 controller.
package qdr2_pkg;
  localparam int BEAT_W  = 36;
  localparam int BURST_W = 72;
  localparam int LANE_W  = 9;
  localparam int LANES   = BEAT_W / LANE_W;

  localparam logic [LANES-1:0] BWS_IDLE = 4'hF;

  typedef enum logic [1:0] {INIT_DOFF, INIT_LOCK, RUN} init_state_t;

  // Byte enables are active high on the host side, byte write selects active low on the pins.
  function automatic logic [LANES-1:0] bws_of(input logic [LANES-1:0] be);
    return ~be;
  endfunction
endpackage

// File: rtl/qdr2_rd_pipe.sv
// Read return path: RD_LAT-deep valid+tag shift register aligned to the captured q pair,
// followed by the registered response stage. Everything is cleared by rst_n.
module qdr2_rd_pipe
  import qdr2_pkg::*;
#(
  parameter int RD_LAT = 3,
  parameter int TAG_W  = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               issue,
  input  logic [TAG_W-1:0]   issue_tag,
  input  logic [BEAT_W-1:0]  q_rise,
  input  logic [BEAT_W-1:0]  q_fall,
  output logic               rsp_valid,
  output logic [BURST_W-1:0] rsp_data,
  output logic [TAG_W-1:0]   rsp_tag
);
  logic [RD_LAT-1:0] vld_sr;
  logic [TAG_W-1:0]  tag_sr [RD_LAT];

  // issue is the registered rps cycle, so the last stage lines up with the cycle q is presented.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_sr    <= '0;
      for (int i = 0; i < RD_LAT; i++) tag_sr[i] <= '0;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      rsp_tag   <= '0;
    end else begin
      vld_sr[0] <= issue;
      tag_sr[0] <= issue_tag;
      for (int i = 1; i < RD_LAT; i++) begin
        vld_sr[i] <= vld_sr[i-1];
        tag_sr[i] <= tag_sr[i-1];
      end
      rsp_valid <= vld_sr[RD_LAT-1];
      if (vld_sr[RD_LAT-1]) begin
        rsp_data <= {q_fall, q_rise};
        rsp_tag  <= tag_sr[RD_LAT-1];
      end
    end
  end
endmodule

// File: rtl/qdr2_b2_ctrl.sv
// QDR-II B2 x36 host controller: DOFF/DLL start-up, SDR rise/fall pin pairs, tagged fixed-latency reads.
// Byte-lane write masking is compiled in with QDR2_CTRL_BYTE_MASK_EN; otherwise all writes are full bursts.
module qdr2_b2_ctrl
  import qdr2_pkg::*;
#(
  parameter int AW       = 19,
  parameter int RD_LAT   = 3,
  parameter int TAG_W    = 4,
  parameter int DOFF_CYC = 16,
  parameter int LOCK_CYC = 1024
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               wr_valid,
  output logic               wr_ready,
  input  logic [AW-1:0]      wr_addr,
  input  logic [BURST_W-1:0] wr_data,
  input  logic [7:0]         wr_be,
  input  logic               rd_valid,
  output logic               rd_ready,
  input  logic [AW-1:0]      rd_addr,
  input  logic [TAG_W-1:0]   rd_tag,
  output logic               rsp_valid,
  output logic [BURST_W-1:0] rsp_data,
  output logic [TAG_W-1:0]   rsp_tag,
  output logic               qdr_rps_n,
  output logic               qdr_wps_n,
  output logic [AW-1:0]      qdr_a_rise,
  output logic [AW-1:0]      qdr_a_fall,
  output logic [BEAT_W-1:0]  qdr_d_rise,
  output logic [BEAT_W-1:0]  qdr_d_fall,
  output logic [LANES-1:0]   qdr_bws_n_rise,
  output logic [LANES-1:0]   qdr_bws_n_fall,
  input  logic [BEAT_W-1:0]  qdr_q_rise,
  input  logic [BEAT_W-1:0]  qdr_q_fall,
  output logic               qdr_doff_n,
  output logic               cal_done
);
  localparam int CNT_MAX = (DOFF_CYC > LOCK_CYC) ? DOFF_CYC : LOCK_CYC;
  localparam int CNT_W   = $clog2(CNT_MAX + 2);

  init_state_t        state;
  logic [CNT_W-1:0]   cnt;
  logic               wr_fire;
  logic               rd_fire;
  logic               wd_pend;
  logic [BURST_W-1:0] wdat_q;
  logic [TAG_W-1:0]   rtag_q;
`ifdef QDR2_CTRL_BYTE_MASK_EN
  logic [7:0]         wbe_q;
`else
  logic               unused_be;
  assign unused_be = ^wr_be;
`endif

  assign wr_ready = (state == RUN);
  assign rd_ready = (state == RUN);
  assign wr_fire  = wr_valid & wr_ready;
  assign rd_fire  = rd_valid & rd_ready;

  // Counters saturate; a zero-length phase still occupies exactly one cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= INIT_DOFF;
      cnt        <= '0;
      qdr_doff_n <= 1'b0;
      cal_done   <= 1'b0;
    end else begin
      case (state)
        INIT_DOFF: begin
          if (int'(cnt) + 1 >= DOFF_CYC) begin
            state      <= INIT_LOCK;
            qdr_doff_n <= 1'b1;
            cnt        <= '0;
          end else if (cnt != '1) begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        INIT_LOCK: begin
          if (int'(cnt) + 1 >= LOCK_CYC) begin
            state    <= RUN;
            cal_done <= 1'b1;
            cnt      <= '0;
          end else if (cnt != '1) begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        RUN:     state <= RUN;
        default: state <= INIT_DOFF;
      endcase
    end
  end

  // Command/address go out one cycle after accept; write data follows one cycle later.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      qdr_rps_n      <= 1'b1;
      qdr_wps_n      <= 1'b1;
      qdr_a_rise     <= '0;
      qdr_a_fall     <= '0;
      qdr_d_rise     <= '0;
      qdr_d_fall     <= '0;
      qdr_bws_n_rise <= BWS_IDLE;
      qdr_bws_n_fall <= BWS_IDLE;
      wd_pend        <= 1'b0;
      wdat_q         <= '0;
      rtag_q         <= '0;
`ifdef QDR2_CTRL_BYTE_MASK_EN
      wbe_q          <= '0;
`endif
    end else begin
      qdr_rps_n <= ~rd_fire;
      qdr_wps_n <= ~wr_fire;
      wd_pend   <= wr_fire;
      if (rd_fire) begin
        qdr_a_rise <= rd_addr;
        rtag_q     <= rd_tag;
      end
      if (wr_fire) begin
        qdr_a_fall <= wr_addr;
        wdat_q     <= wr_data;
`ifdef QDR2_CTRL_BYTE_MASK_EN
        wbe_q      <= wr_be;
`endif
      end
      if (wd_pend) begin
        qdr_d_rise <= wdat_q[BEAT_W-1:0];
        qdr_d_fall <= wdat_q[BURST_W-1:BEAT_W];
`ifdef QDR2_CTRL_BYTE_MASK_EN
        qdr_bws_n_rise <= bws_of(wbe_q[LANES-1:0]);
        qdr_bws_n_fall <= bws_of(wbe_q[2*LANES-1:LANES]);
`else
        qdr_bws_n_rise <= '0;
        qdr_bws_n_fall <= '0;
`endif
      end else begin
        qdr_bws_n_rise <= BWS_IDLE;
        qdr_bws_n_fall <= BWS_IDLE;
      end
    end
  end

  qdr2_rd_pipe #(.RD_LAT(RD_LAT), .TAG_W(TAG_W)) u_rd_pipe (
    .clk       (clk),
    .rst_n     (rst_n),
    .issue     (~qdr_rps_n),
    .issue_tag (rtag_q),
    .q_rise    (qdr_q_rise),
    .q_fall    (qdr_q_fall),
    .rsp_valid (rsp_valid),
    .rsp_data  (rsp_data),
    .rsp_tag   (rsp_tag)
  );
endmodule

// File: tb/tb_qdr2_b2_ctrl.sv
// Directed bench for qdr2_b2_ctrl with a behavioural cyqdr2_b2 memory model on the pin side.
module tb_qdr2_b2_ctrl;
  localparam int AW = 19, RD_LAT = 3, TAG_W = 4, DOFF_CYC = 16, LOCK_CYC = 1024;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic wr_valid = 1'b0, rd_valid = 1'b0;
  logic wr_ready, rd_ready;
  logic [AW-1:0] wr_addr = '0, rd_addr = '0;
  logic [71:0] wr_data = '0;
  logic [7:0] wr_be = '0;
  logic [TAG_W-1:0] rd_tag = '0;
  logic rsp_valid;
  logic [71:0] rsp_data;
  logic [TAG_W-1:0] rsp_tag;
  logic qdr_rps_n, qdr_wps_n, qdr_doff_n, cal_done;
  logic [AW-1:0] qdr_a_rise, qdr_a_fall;
  logic [35:0] qdr_d_rise, qdr_d_fall;
  logic [3:0] qdr_bws_n_rise, qdr_bws_n_fall;
  logic [35:0] qdr_q_rise = '0, qdr_q_fall = '0;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;

  qdr2_b2_ctrl #(.AW(AW), .RD_LAT(RD_LAT), .TAG_W(TAG_W), .DOFF_CYC(DOFF_CYC), .LOCK_CYC(LOCK_CYC)) dut (
    .clk(clk), .rst_n(rst_n),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data), .wr_be(wr_be),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_addr(rd_addr), .rd_tag(rd_tag),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_tag(rsp_tag),
    .qdr_rps_n(qdr_rps_n), .qdr_wps_n(qdr_wps_n), .qdr_a_rise(qdr_a_rise), .qdr_a_fall(qdr_a_fall),
    .qdr_d_rise(qdr_d_rise), .qdr_d_fall(qdr_d_fall),
    .qdr_bws_n_rise(qdr_bws_n_rise), .qdr_bws_n_fall(qdr_bws_n_fall),
    .qdr_q_rise(qdr_q_rise), .qdr_q_fall(qdr_q_fall),
    .qdr_doff_n(qdr_doff_n), .cal_done(cal_done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Memory model: write data lands the cycle after wps_n; reads look up in the rps_n cycle
  // and present q RD_LAT cycles later. Also records every response the DUT produces.
  logic [71:0] mem [logic [AW-1:0]];
  logic [71:0] qpipe [RD_LAT+1] = '{default: '0};
  logic pw_vld = 1'b0;
  logic [AW-1:0] pw_addr = '0;
  logic [71:0] mword;
  int rsp_cyc[$];
  logic [TAG_W-1:0] rsp_tg[$];
  logic [71:0] rsp_dt[$];

  always @(negedge clk) begin
    if (pw_vld) begin
      mword = mem.exists(pw_addr) ? mem[pw_addr] : 72'h0;
      for (int l = 0; l < 4; l++) begin
        if (!qdr_bws_n_rise[l]) mword[9*l +: 9] = qdr_d_rise[9*l +: 9];
        if (!qdr_bws_n_fall[l]) mword[36 + 9*l +: 9] = qdr_d_fall[9*l +: 9];
      end
      mem[pw_addr] = mword;
    end
    pw_vld  = !qdr_wps_n;
    pw_addr = qdr_a_fall;
    for (int k = RD_LAT; k > 0; k--) qpipe[k] = qpipe[k-1];
    if (!qdr_rps_n) qpipe[0] = mem.exists(qdr_a_rise) ? mem[qdr_a_rise] : 72'h0;
    else qpipe[0] = 72'h0;
    {qdr_q_fall, qdr_q_rise} = qpipe[RD_LAT];
    if (rsp_valid) begin
      rsp_cyc.push_back(cyc);
      rsp_tg.push_back(rsp_tag);
      rsp_dt.push_back(rsp_data);
    end
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic clear_rsp();
    rsp_cyc.delete();
    rsp_tg.delete();
    rsp_dt.delete();
  endtask

  function automatic logic [71:0] wdat(input int i);
    return {36'hC_0000_0000 + 36'(i), 36'h0_5A5A_0000 + 36'(i)};
  endfunction

  task automatic test_reset();
    int c0, doff_at, done_at, act, rdy_early, rdy_at_done;
    logic [14:0] obs_hi;
    rst_n = 1'b0;
    repeat (3) step();
    obs_hi = {qdr_rps_n, qdr_wps_n, qdr_bws_n_rise, qdr_bws_n_fall, qdr_doff_n, cal_done, wr_ready, rd_ready, rsp_valid};
    n_cmp++;
    if (obs_hi !== {2'b11, 8'hFF, 5'b00000}) begin
      n_bad++; $display("FAIL reset_ctrl: got %b want %b", obs_hi, {2'b11, 8'hFF, 5'b00000});
    end
    n_cmp++;
    if ({qdr_a_rise, qdr_a_fall, qdr_d_rise, qdr_d_fall, rsp_data, rsp_tag} !== '0) begin
      n_bad++; $display("FAIL reset_data: a_rise=%h a_fall=%h d=%h/%h rsp=%h tag=%h want 0",
                        qdr_a_rise, qdr_a_fall, qdr_d_rise, qdr_d_fall, rsp_data, rsp_tag);
    end
    rst_n = 1'b1;
    c0 = cyc; doff_at = -1; done_at = -1; act = 0; rdy_early = 0; rdy_at_done = 0;
    for (int k = 0; k < 2000 && done_at < 0; k++) begin
      if (doff_at < 0 && qdr_doff_n) doff_at = cyc - c0;
      if (cal_done) begin
        done_at = cyc - c0;
        rdy_at_done = int'(wr_ready & rd_ready);
      end else if (wr_ready || rd_ready) rdy_early++;
      if (!qdr_rps_n || !qdr_wps_n) act++;
      if (done_at < 0) step();
    end
    n_cmp++;
    if (doff_at !== 16) begin n_bad++; $display("FAIL doff_rise_cycle: got %0d want 16", doff_at); end
    n_cmp++;
    if (done_at !== 1040) begin n_bad++; $display("FAIL cal_done_cycle: got %0d want 1040", done_at); end
    n_cmp++;
    if (rdy_at_done !== 1 || rdy_early !== 0) begin
      n_bad++; $display("FAIL ready_timing: at_done=%0d early=%0d want 1/0", rdy_at_done, rdy_early);
    end
    n_cmp++;
    if (act !== 0) begin n_bad++; $display("FAIL init_pin_activity: got %0d want 0", act); end
  endtask

  task automatic test_write();
    wr_valid = 1'b1; wr_addr = 19'h00005; wr_be = 8'hFF;
    wr_data = {36'hA5A5A5A5A, 36'h123456789};
    step();
    wr_valid = 1'b0;
    n_cmp++;
    if (qdr_wps_n !== 1'b0 || qdr_a_fall !== 19'h5 || qdr_rps_n !== 1'b1) begin
      n_bad++; $display("FAIL write_cmd: wps_n=%b a_fall=%h rps_n=%b want 0/5/1", qdr_wps_n, qdr_a_fall, qdr_rps_n);
    end
    step();
    n_cmp++;
    if (qdr_d_rise !== 36'h123456789 || qdr_d_fall !== 36'hA5A5A5A5A) begin
      n_bad++; $display("FAIL write_data: d_rise=%h d_fall=%h want 123456789/a5a5a5a5a", qdr_d_rise, qdr_d_fall);
    end
    n_cmp++;
    if (qdr_bws_n_rise !== 4'h0 || qdr_bws_n_fall !== 4'h0 || qdr_wps_n !== 1'b1) begin
      n_bad++; $display("FAIL write_bws: rise=%h fall=%h wps_n=%b want 0/0/1", qdr_bws_n_rise, qdr_bws_n_fall, qdr_wps_n);
    end
    step();
    n_cmp++;
    if (qdr_bws_n_rise !== 4'hF || qdr_bws_n_fall !== 4'hF || qdr_d_rise !== 36'h123456789) begin
      n_bad++; $display("FAIL write_idle: bws=%h/%h d_rise=%h want f/f/123456789", qdr_bws_n_rise, qdr_bws_n_fall, qdr_d_rise);
    end
  endtask

  task automatic test_read();
    int n0;
    clear_rsp();
    n0 = cyc;
    rd_valid = 1'b1; rd_addr = 19'h5; rd_tag = 4'd3;
    step();
    rd_valid = 1'b0;
    n_cmp++;
    if (qdr_rps_n !== 1'b0 || qdr_a_rise !== 19'h5) begin
      n_bad++; $display("FAIL read_cmd: rps_n=%b a_rise=%h want 0/5", qdr_rps_n, qdr_a_rise);
    end
    for (int k = 0; k < 20 && rsp_cyc.size() == 0; k++) step();
    n_cmp++;
    if (rsp_cyc.size() == 0) begin
      n_bad++; $display("FAIL read_timeout: no rsp_valid within 20 cycles");
    end else if (rsp_cyc[0] - n0 !== RD_LAT + 2 || rsp_tg[0] !== 4'd3 ||
                 rsp_dt[0] !== {36'hA5A5A5A5A, 36'h123456789}) begin
      n_bad++; $display("FAIL read_rsp: lat=%0d tag=%0d data=%h want %0d/3/a5a5a5a5a123456789",
                        rsp_cyc[0] - n0, rsp_tg[0], rsp_dt[0], RD_LAT + 2);
    end
  endtask

  task automatic test_back_to_back();
    int n0;
    clear_rsp();
    n0 = cyc;
    for (int i = 0; i < 8; i++) begin
      rd_valid = 1'b1; rd_addr = 19'h100 + 19'(i); rd_tag = 4'(i);
      wr_valid = 1'b1; wr_addr = 19'h100 + 19'(i); wr_data = wdat(i); wr_be = 8'hFF;
      step();
      n_cmp++;
      if (qdr_rps_n !== 1'b0 || qdr_wps_n !== 1'b0 || qdr_a_rise !== 19'h100 + 19'(i) || qdr_a_fall !== 19'h100 + 19'(i)) begin
        n_bad++; $display("FAIL b2b_issue%0d: rps_n=%b wps_n=%b a=%h/%h", i, qdr_rps_n, qdr_wps_n, qdr_a_rise, qdr_a_fall);
      end
    end
    rd_valid = 1'b0; wr_valid = 1'b0;
    repeat (12) step();
    n_cmp++;
    if (rsp_cyc.size() !== 8) begin
      n_bad++; $display("FAIL b2b_count: got %0d want 8", rsp_cyc.size());
    end else begin
      for (int j = 0; j < 8; j++) begin
        n_cmp++;
        // Same-cycle write to the same address must not be visible: memory was never written.
        if (rsp_tg[j] !== 4'(j) || rsp_cyc[j] - n0 !== j + RD_LAT + 2 || rsp_dt[j] !== 72'h0) begin
          n_bad++; $display("FAIL b2b_rsp%0d: tag=%0d lat=%0d data=%h want %0d/%0d/0",
                            j, rsp_tg[j], rsp_cyc[j] - n0, rsp_dt[j], j, j + RD_LAT + 2);
        end
      end
    end
    clear_rsp();
    for (int i = 0; i < 8; i++) begin
      rd_valid = 1'b1; rd_addr = 19'h100 + 19'(i); rd_tag = 4'(7 - i);
      step();
    end
    rd_valid = 1'b0;
    repeat (12) step();
    n_cmp++;
    if (rsp_cyc.size() !== 8) begin
      n_bad++; $display("FAIL b2b_readback_count: got %0d want 8", rsp_cyc.size());
    end else begin
      for (int j = 0; j < 8; j++) begin
        n_cmp++;
        if (rsp_tg[j] !== 4'(7 - j) || rsp_dt[j] !== wdat(j)) begin
          n_bad++; $display("FAIL b2b_readback%0d: tag=%0d data=%h want %0d/%h", j, rsp_tg[j], rsp_dt[j], 7 - j, wdat(j));
        end
      end
    end
  endtask

  task automatic test_byte_mask();
    logic [3:0] exp_f;
    logic [71:0] exp_rd;
`ifdef QDR2_CTRL_BYTE_MASK_EN
    exp_f = 4'hF; exp_rd = {36'hF_FFFF_FFFF, 36'h0};
`else
    exp_f = 4'h0; exp_rd = 72'h0;
`endif
    clear_rsp();
    wr_valid = 1'b1; wr_addr = 19'h7FFFF; wr_data = '1; wr_be = 8'hFF;
    step();
    wr_data = '0; wr_be = 8'h0F;
    step();
    wr_valid = 1'b0;
    step();
    n_cmp++;
    if (qdr_bws_n_rise !== 4'h0 || qdr_bws_n_fall !== exp_f) begin
      n_bad++; $display("FAIL mask_bws: rise=%h fall=%h want 0/%h", qdr_bws_n_rise, qdr_bws_n_fall, exp_f);
    end
    rd_valid = 1'b1; rd_addr = 19'h7FFFF; rd_tag = 4'd9;
    step();
    rd_valid = 1'b0;
    for (int k = 0; k < 20 && rsp_cyc.size() == 0; k++) step();
    n_cmp++;
    if (rsp_cyc.size() == 0) begin
      n_bad++; $display("FAIL mask_timeout: no rsp_valid within 20 cycles");
    end else if (rsp_dt[0] !== exp_rd || rsp_tg[0] !== 4'd9) begin
      n_bad++; $display("FAIL mask_readback: data=%h tag=%0d want %h/9", rsp_dt[0], rsp_tg[0], exp_rd);
    end
  endtask

  task automatic test_reset_inflight();
    int c0, doff_at;
    logic [14:0] obs_hi;
    clear_rsp();
    rd_valid = 1'b1; rd_addr = 19'h5; rd_tag = 4'd1;
    wr_valid = 1'b1; wr_addr = 19'h6; wr_data = wdat(20); wr_be = 8'hFF;
    step();
    rd_tag = 4'd2; wr_addr = 19'h7;
    step();
    rd_valid = 1'b0; wr_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    obs_hi = {qdr_rps_n, qdr_wps_n, qdr_bws_n_rise, qdr_bws_n_fall, qdr_doff_n, cal_done, wr_ready, rd_ready, rsp_valid};
    n_cmp++;
    if (obs_hi !== {2'b11, 8'hFF, 5'b00000}) begin
      n_bad++; $display("FAIL midrst_ctrl: got %b want %b", obs_hi, {2'b11, 8'hFF, 5'b00000});
    end
    n_cmp++;
    if ({qdr_a_rise, qdr_a_fall, qdr_d_rise, qdr_d_fall, rsp_data, rsp_tag} !== '0) begin
      n_bad++; $display("FAIL midrst_data: a=%h/%h d=%h/%h rsp=%h tag=%h want 0",
                        qdr_a_rise, qdr_a_fall, qdr_d_rise, qdr_d_fall, rsp_data, rsp_tag);
    end
    repeat (3) step();
    rst_n = 1'b1;
    c0 = cyc; doff_at = -1;
    for (int k = 0; k < 40; k++) begin
      if (doff_at < 0 && qdr_doff_n) doff_at = cyc - c0;
      step();
    end
    n_cmp++;
    if (rsp_cyc.size() !== 0) begin n_bad++; $display("FAIL midrst_rsp: got %0d responses want 0", rsp_cyc.size()); end
    n_cmp++;
    if (doff_at !== 16) begin n_bad++; $display("FAIL midrst_doff: rise at %0d want 16", doff_at); end
    n_cmp++;
    if (cal_done !== 1'b0 || wr_ready !== 1'b0) begin
      n_bad++; $display("FAIL midrst_lock: cal_done=%b wr_ready=%b want 0/0", cal_done, wr_ready);
    end
  endtask

  initial begin
    test_reset();
    test_write();
    test_read();
    test_back_to_back();
    test_byte_mask();
    test_reset_inflight();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
